dmem_bus_arbiter: RTL and testbench
===================================

Name: dmem_bus_arbiter

Overview:
- Shares the single-port data memory (DMEMWORDS x DBITS, word-addressed) between the CPU MEM stage and a second master (DMA/debug loader).
- Decides ownership every cycle, muxes address/data/write-enable to the memory, and returns registered read data one cycle later to the winning master.
- Raises stall_cpu when the CPU loses arbitration so the pipeline holds the MEM-stage instruction.
- Provides starvation protection and a DMA bus-lock for atomic multi-word transfers.

Parameters:
- DBITS, 32, data width.
- DMEMADDRBITS, 16, byte-address bits decoded into memory.
- DMEMWORDBITS, 2, byte-offset bits dropped (word index = addr[DMEMADDRBITS-1:DMEMWORDBITS]).
- MAXWAIT, 4, consecutive DMA-denied cycles before DMA is forced to win (range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  reset (asynchronous, active-high).
- cpu_req  in  1  CPU access request this cycle.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  DBITS  CPU byte address.
- cpu_wdata  in  DBITS  CPU store data.
- cpu_gnt  out  1  CPU owns the memory this cycle (combinational).
- cpu_rvalid  out  1  registered read data for CPU valid.
- cpu_rdata  out  DBITS  CPU read data.
- dma_req, dma_we  in  1  DMA request / write.
- dma_addr, dma_wdata  in  DBITS  DMA byte address / write data.
- dma_lock  in  1  DMA requests that ownership be held after this grant.
- dma_gnt  out  1  DMA owns the memory this cycle (combinational).
- dma_rvalid  out  1  registered read data for DMA valid.
- dma_rdata  out  DBITS  DMA read data.
- mem_en, mem_we  out  1  memory access enable / write enable.
- mem_addr  out  DMEMADDRBITS-DMEMWORDBITS  word index.
- mem_wdata  out  DBITS  memory write data.
- mem_rdata  in  DBITS  memory read data (combinational array read of mem_addr).
- stall_cpu  out  1  cpu_req && !cpu_gnt.

Behaviour:
- State register: NORMAL, LOCKED. Reset -> NORMAL. starve_cnt (4 bits) = 0. rvalid/rdata registers = 0. Reset mid-lock forces NORMAL and drops ownership the same instant.
- Grant (combinational from state, reqs, starve_cnt):
  - In NORMAL: CPU wins if cpu_req and not (dma_req and starve_cnt >= MAXWAIT); otherwise DMA wins if dma_req.
  - In LOCKED: DMA wins whenever dma_req; CPU is never granted (stall_cpu = cpu_req).
  - cpu_gnt and dma_gnt are never both 1.
- Memory mux:
  - mem_en = cpu_gnt|dma_gnt.
  - mem_we = gnt & the winner's we.
  - addr/wdata come from the winner.
  - With no grant, mem_we = 0 and addr/wdata = 0.
- Read return, 1-cycle latency:
  - On each posedge, x_rvalid <= x_gnt & !x_we.
  - x_rdata <= mem_rdata when that master has a read grant; otherwise x_rdata holds.
  - Writes produce no rvalid.
- starve_cnt:
  - Increments (saturating at 15) each cycle with dma_req && !dma_gnt.
  - Clears on any cycle with dma_gnt or !dma_req.
- Lock transitions:
  - NORMAL -> LOCKED at posedge when dma_gnt && dma_lock.
  - LOCKED -> NORMAL at posedge when !dma_lock, or when !dma_req (lock abandoned).
  - A grant in the cycle dma_lock falls is still honoured.
- Simultaneous first-cycle requests with starve_cnt = 0: CPU wins; DMA waits up to MAXWAIT cycles, then wins one cycle; the counter clears and the CPU regains priority.
- Address: only addr[DMEMADDRBITS-1:DMEMWORDBITS] is used. Upper bits are ignored; aliasing wraps by design, and memory-mapped I/O decode stays outside this block.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds outputs stat_cpu_grants, stat_dma_grants and stat_conflicts, each 16 bits.
  - stat_cpu_grants and stat_dma_grants count grant cycles.
  - stat_conflicts counts cycles with cpu_req && dma_req.
  - All wrap at 16'hFFFF -> 0 and reset to 0.
- Undefined: ports and counters are absent; arbitration is identical.

Test Plan:
- CPU read alone, addr 32'h100, mem word 0x40 = 32'hDEADBEEF -> cpu_gnt = 1 and mem_addr = 14'h40 the same cycle; next cycle cpu_rvalid = 1 and cpu_rdata = 32'hDEADBEEF; stall_cpu = 0 throughout.
- CPU and DMA both requesting continuously, MAXWAIT = 4 -> cpu_gnt for cycles 0-3; dma_gnt in cycle 4 with stall_cpu = 1; pattern repeats every 5 cycles and gnt is never both 1.
- DMA writes with dma_lock = 1 for 3 words (addrs 0x200, 0x204, 0x208, data 1, 2, 3) while the CPU requests -> 3 consecutive dma_gnt cycles, stall_cpu = 1 for all 3, memory holds 1/2/3; CPU is granted the cycle after lock drops.
- Assert reset while LOCKED with both requesting -> all gnt/rvalid go to 0 immediately; after reset release the CPU is granted first (NORMAL state, starve_cnt = 0).
- DMA store then CPU load to the same address 0x300 on consecutive cycles -> CPU rdata equals the DMA-written value; dma_rvalid stays 0 for the write.
- With ARB_STATS_EN, run 10 cycles with both requesting and MAXWAIT = 4 -> stat_cpu_grants = 8, stat_dma_grants = 2, stat_conflicts = 10.

Source files
------------

// File: rtl/dmem_bus_arbiter_if.sv
// Data-memory bus bundle: CPU port, DMA port and the shared memory port.
// With ARB_STATS_EN defined, the bundle also carries the grant/conflict counters.
interface dmem_bus_arbiter_if #(
    parameter int DBITS        = 32,
    parameter int DMEMADDRBITS = 16,
    parameter int DMEMWORDBITS = 2
);
    localparam int AW = DMEMADDRBITS - DMEMWORDBITS;

    logic             cpu_req;
    logic             cpu_we;
    logic [DBITS-1:0] cpu_addr;
    logic [DBITS-1:0] cpu_wdata;
    logic             cpu_gnt;
    logic             cpu_rvalid;
    logic [DBITS-1:0] cpu_rdata;

    logic             dma_req;
    logic             dma_we;
    logic [DBITS-1:0] dma_addr;
    logic [DBITS-1:0] dma_wdata;
    logic             dma_lock;
    logic             dma_gnt;
    logic             dma_rvalid;
    logic [DBITS-1:0] dma_rdata;

    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DBITS-1:0] mem_wdata;
    logic [DBITS-1:0] mem_rdata;

    logic             stall_cpu;

`ifdef ARB_STATS_EN
    logic [15:0]      stat_cpu_grants;
    logic [15:0]      stat_dma_grants;
    logic [15:0]      stat_conflicts;
`endif

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
`ifdef ARB_STATS_EN
        output stat_cpu_grants, stat_dma_grants, stat_conflicts,
`endif
        output stall_cpu
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
`ifdef ARB_STATS_EN
        input  stat_cpu_grants, stat_dma_grants, stat_conflicts,
`endif
        input  stall_cpu
    );

endinterface

// File: rtl/dmem_bus_arbiter.sv
// CPU/DMA arbiter for the single-port data memory, with starvation guard and DMA lock.
// Optional grant/conflict counters are enabled by defining ARB_STATS_EN.
module dmem_bus_arbiter #(
    parameter int DBITS        = 32,
    parameter int DMEMADDRBITS = 16,
    parameter int DMEMWORDBITS = 2,
    parameter int MAXWAIT      = 4
) (
    input logic              clk,
    input logic              reset,
    dmem_bus_arbiter_if.slave bus
);
    localparam int AW = DMEMADDRBITS - DMEMWORDBITS;
    localparam logic [3:0] MAXWAIT_C = 4'(MAXWAIT);

    typedef enum logic {
        ST_NORMAL,
        ST_LOCKED
    } state_e;

    state_e state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic cpu_rvalid_q, cpu_rvalid_d;
    logic dma_rvalid_q, dma_rvalid_d;
    logic [DBITS-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DBITS-1:0] dma_rdata_q, dma_rdata_d;

    logic cpu_gnt;
    logic dma_gnt;
    logic starved;
    logic cpu_rd;
    logic dma_rd;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.cpu_addr[DBITS-1:DMEMADDRBITS],
                                bus.cpu_addr[DMEMWORDBITS-1:0],
                                bus.dma_addr[DBITS-1:DMEMADDRBITS],
                                bus.dma_addr[DMEMWORDBITS-1:0]};

    // Grants are gated by reset so ownership drops the instant reset rises.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        starved = bus.dma_req && (starve_cnt_q >= MAXWAIT_C);
        if (!reset) begin
            unique case (state_q)
                ST_NORMAL: begin
                    cpu_gnt = bus.cpu_req && !starved;
                    dma_gnt = bus.dma_req && !cpu_gnt;
                end
                ST_LOCKED: begin
                    dma_gnt = bus.dma_req;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_NORMAL: begin
                if (dma_gnt && bus.dma_lock) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (!bus.dma_lock || !bus.dma_req) state_d = ST_NORMAL;
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_comb begin
        starve_cnt_d = 4'd0;
        if (bus.dma_req && !dma_gnt) begin
            starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (1'b1)
            cpu_gnt: begin
                bus.mem_we    = bus.cpu_we;
                bus.mem_addr  = bus.cpu_addr[DMEMADDRBITS-1:DMEMWORDBITS];
                bus.mem_wdata = bus.cpu_wdata;
            end
            dma_gnt: begin
                bus.mem_we    = bus.dma_we;
                bus.mem_addr  = bus.dma_addr[DMEMADDRBITS-1:DMEMWORDBITS];
                bus.mem_wdata = bus.dma_wdata;
            end
            default: ;
        endcase
    end

    assign cpu_rd = cpu_gnt && !bus.cpu_we;
    assign dma_rd = dma_gnt && !bus.dma_we;

    always_comb begin
        cpu_rvalid_d = cpu_rd;
        dma_rvalid_d = dma_rd;
        cpu_rdata_d  = cpu_rd ? bus.mem_rdata : cpu_rdata_q;
        dma_rdata_d  = dma_rd ? bus.mem_rdata : dma_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= 4'd0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.mem_en     = cpu_gnt | dma_gnt;
    assign bus.stall_cpu  = bus.cpu_req && !cpu_gnt;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dma_rdata  = dma_rdata_q;

`ifdef ARB_STATS_EN
    logic [15:0] stat_cpu_q, stat_cpu_d;
    logic [15:0] stat_dma_q, stat_dma_d;
    logic [15:0] stat_conf_q, stat_conf_d;

    // Counters wrap naturally at 16 bits.
    always_comb begin
        stat_cpu_d  = stat_cpu_q + 16'(cpu_gnt);
        stat_dma_d  = stat_dma_q + 16'(dma_gnt);
        stat_conf_d = stat_conf_q + 16'(bus.cpu_req && bus.dma_req);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_cpu_q  <= 16'd0;
            stat_dma_q  <= 16'd0;
            stat_conf_q <= 16'd0;
        end else begin
            stat_cpu_q  <= stat_cpu_d;
            stat_dma_q  <= stat_dma_d;
            stat_conf_q <= stat_conf_d;
        end
    end

    assign bus.stat_cpu_grants = stat_cpu_q;
    assign bus.stat_dma_grants = stat_dma_q;
    assign bus.stat_conflicts  = stat_conf_q;
`endif

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter with a behavioural data memory.
// Counter checks are included when ARB_STATS_EN is defined.
module tb_dmem_bus_arbiter;
    localparam int DBITS = 32;
    localparam int AW    = 14;

    logic clk;
    logic reset;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;
    logic [31:0]   mem [0:(1<<AW)-1];

    int n_checks;
    int n_errors;

    dmem_bus_arbiter_if #(
        .DBITS(32), .DMEMADDRBITS(16), .DMEMWORDBITS(2)
    ) bus ();

    dmem_bus_arbiter #(
        .DBITS(32), .DMEMADDRBITS(16), .DMEMWORDBITS(2), .MAXWAIT(4)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd,
                         input logic dl);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.dma_req   = dr;
        bus.dma_we    = dw;
        bus.dma_addr  = da;
        bus.dma_wdata = dd;
        bus.dma_lock  = dl;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        pre_we   = 1'b1;
        pre_addr = 14'h40;
        pre_data = 32'hDEADBEEF;
        idle();
        tick();
        pre_we = 1'b0;
        tick();

        // reset state with a CPU request pending
        drive(1, 0, 32'h100, 0, 1, 0, 32'h104, 0, 0);
        check("rst_cpu_gnt", 32'(bus.cpu_gnt), 0);
        check("rst_dma_gnt", 32'(bus.dma_gnt), 0);
        check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("rst_mem_en", 32'(bus.mem_en), 0);
        idle();
        reset = 1'b0;
        #1;

        // contention: 4 CPU cycles then one forced DMA cycle, repeating
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 32'h100, 0, 1, 0, 32'h104, 0, 0);
            check($sformatf("rr_cpu_gnt%0d", i), 32'(bus.cpu_gnt),
                  32'((i % 5) != 4));
            check($sformatf("rr_dma_gnt%0d", i), 32'(bus.dma_gnt),
                  32'((i % 5) == 4));
            check($sformatf("rr_stall%0d", i), 32'(bus.stall_cpu),
                  32'((i % 5) == 4));
            check($sformatf("rr_excl%0d", i), 32'(bus.cpu_gnt & bus.dma_gnt), 0);
            tick();
        end
`ifdef ARB_STATS_EN
        check("stat_cpu", 32'(bus.stat_cpu_grants), 8);
        check("stat_dma", 32'(bus.stat_dma_grants), 2);
        check("stat_conf", 32'(bus.stat_conflicts), 10);
`endif
        idle();
        tick();

        // CPU read alone
        drive(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
        check("rd_cpu_gnt", 32'(bus.cpu_gnt), 1);
        check("rd_mem_addr", 32'(bus.mem_addr), 32'h40);
        check("rd_mem_we", 32'(bus.mem_we), 0);
        check("rd_stall", 32'(bus.stall_cpu), 0);
        tick();
        idle();
        check("rd_rvalid", 32'(bus.cpu_rvalid), 1);
        check("rd_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        check("rd_stall2", 32'(bus.stall_cpu), 0);
        tick();
        check("rd_rvalid_drop", 32'(bus.cpu_rvalid), 0);
        check("rd_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);

        // upper address bits alias
        drive(1, 0, 32'hFFFF_0104, 0, 0, 0, 0, 0, 0);
        check("alias_mem_addr", 32'(bus.mem_addr), 32'h41);
        idle();
        tick();

        // locked DMA burst while the CPU keeps requesting
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h100, 0, 1, 1, 32'h200, 1, 1);
            check($sformatf("lk_pre_cpu%0d", i), 32'(bus.cpu_gnt), 1);
            tick();
        end
        drive(1, 0, 32'h100, 0, 1, 1, 32'h200, 1, 1);
        check("lk_w1_gnt", 32'(bus.dma_gnt), 1);
        check("lk_w1_stall", 32'(bus.stall_cpu), 1);
        check("lk_w1_we", 32'(bus.mem_we), 1);
        tick();
        drive(1, 0, 32'h100, 0, 1, 1, 32'h204, 2, 1);
        check("lk_w2_gnt", 32'(bus.dma_gnt), 1);
        check("lk_w2_stall", 32'(bus.stall_cpu), 1);
        tick();
        drive(1, 0, 32'h100, 0, 1, 1, 32'h208, 3, 0);
        check("lk_w3_gnt", 32'(bus.dma_gnt), 1);
        check("lk_w3_stall", 32'(bus.stall_cpu), 1);
        check("lk_w3_dma_rvalid", 32'(bus.dma_rvalid), 0);
        tick();
        drive(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
        check("lk_after_cpu", 32'(bus.cpu_gnt), 1);
        check("lk_mem0", mem[14'h80], 1);
        check("lk_mem1", mem[14'h81], 2);
        check("lk_mem2", mem[14'h82], 3);
        idle();
        tick();

        // reset while locked and both requesting
        drive(0, 0, 0, 0, 1, 0, 32'h100, 0, 1);
        check("rl_dma_first", 32'(bus.dma_gnt), 1);
        tick();
        drive(1, 0, 32'h104, 0, 1, 0, 32'h100, 0, 1);
        check("rl_locked_dma", 32'(bus.dma_gnt), 1);
        check("rl_locked_stall", 32'(bus.stall_cpu), 1);
        tick();
        check("rl_dma_rvalid", 32'(bus.dma_rvalid), 1);
        check("rl_dma_rdata", bus.dma_rdata, 32'hDEADBEEF);
        reset = 1'b1;
        #1;
        check("rl_cpu_gnt", 32'(bus.cpu_gnt), 0);
        check("rl_dma_gnt", 32'(bus.dma_gnt), 0);
        check("rl_dma_rvalid0", 32'(bus.dma_rvalid), 0);
        check("rl_cpu_rvalid0", 32'(bus.cpu_rvalid), 0);
        tick();
        reset = 1'b0;
        #1;
        check("rl_post_cpu", 32'(bus.cpu_gnt), 1);
        check("rl_post_dma", 32'(bus.dma_gnt), 0);
        idle();
        tick();

        // DMA store then CPU load of the same word
        drive(0, 0, 0, 0, 1, 1, 32'h300, 32'hA5A51234, 0);
        check("sl_dma_gnt", 32'(bus.dma_gnt), 1);
        check("sl_mem_addr", 32'(bus.mem_addr), 32'hC0);
        check("sl_mem_wdata", bus.mem_wdata, 32'hA5A51234);
        tick();
        check("sl_dma_rvalid", 32'(bus.dma_rvalid), 0);
        drive(1, 0, 32'h300, 0, 0, 0, 0, 0, 0);
        check("sl_cpu_gnt", 32'(bus.cpu_gnt), 1);
        tick();
        idle();
        check("sl_cpu_rvalid", 32'(bus.cpu_rvalid), 1);
        check("sl_cpu_rdata", bus.cpu_rdata, 32'hA5A51234);
        check("sl_dma_rvalid2", 32'(bus.dma_rvalid), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
